// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store sequencer between the CPU control unit and a word-addressed RAM.
// Latency: WAIT_STATES+3 cycles from accept to resp_valid (1 cycle for an out-of-range
// request when MEM_CTRL_BOUNDS_CHECK_EN is defined). Backpressure: req_ready only in IDLE.
module mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q;
  logic              write_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic accept;
  logic out_of_range;

  // Ready is held low while reset is asserted so nothing is accepted during reset.
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  // Zero-extended compare so DEPTH may equal 2**ADDR_W without overflow.
  assign out_of_range = ({1'b0, req_addr} >= DEPTH_X);
`else
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);
  assign out_of_range = 1'b0;
`endif

  // Controller FSM; every output except req_ready is a register written here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= req_write;
            if (out_of_range) begin
              // Rejected request: answer immediately, never touch the RAM.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              // Address/data go out one cycle ahead of the strobe.
              state_q       <= SETUP;
              mem_address_q <= req_addr;
              mem_data_in_q <= req_write ? req_wdata : '0;
            end
          end
        end
        SETUP: begin
          state_q     <= STROBE;
          cnt_q       <= CNT_W'(WAIT_STATES);
          mem_write_q <= write_q;
          mem_read_q  <= !write_q;
        end
        STROBE: begin
          if (cnt_q == '0) begin
            // Strobe drops while address/data stay put for the RESP cycle.
            state_q      <= RESP;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            if (!write_q) begin
              resp_rdata_q <= mem_data_out;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q       <= IDLE;
          resp_valid_q  <= 1'b0;
          resp_error_q  <= 1'b0;
          mem_address_q <= '0;
          mem_data_in_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_error  = resp_error_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the CPU control unit and the word-addressed RAM. It accepts one load/store request at a time over a valid/ready handshake, sequences the RAM strobes, and returns a one-cycle response. Address and write data are held stable before and after every strobe, so the level-sensitive RAM never sees a write while its address or data is changing. Read data is registered before it is returned.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, address width
- WAIT_STATES, 1, extra strobe cycles beyond the first (0 allowed)
- DEPTH, 512, RAM depth in words (used only by the bounds check)

Clocking and reset: one clock; reset is synchronous and active-high.

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load data, valid with resp_valid
- resp_error  out  1  out-of-range request, valid with resp_valid
- mem_address  out  ADDR_W  to RAM address
- mem_data_in  out  DATA_W  to RAM data_in
- mem_read  out  1  to RAM read
- mem_write  out  1  to RAM write
- mem_data_out  in  DATA_W  from RAM data_out, combinational

## Operation

**States**
- IDLE -> SETUP on accept (req_valid && req_ready).
- SETUP -> STROBE after 1 cycle.
- STROBE -> RESP after WAIT_STATES+1 cycles.
- RESP -> IDLE after 1 cycle.

**Accept**
- Latch req_write, req_addr and req_wdata into internal registers.
- Later changes on the request inputs are ignored until the next accept.

**Request hold**
- req_ready = 1 only in IDLE.
- While the controller is busy, req_valid is ignored. The requester holds it until accept; nothing is queued.

**Address and data drive**
- mem_address is driven from the latched address during SETUP, STROBE and RESP.
- mem_data_in carries the latched data for stores. For loads it is 0.

**Strobes**
- mem_write = 1 (store) or mem_read = 1 (load) only in STROBE.
- Strobes are never both high and are 0 in every other state.

**Strobe counter**
- Loaded with WAIT_STATES on SETUP->STROBE.
- Decrements each STROBE cycle; exit when it is 0.
- Width is clog2(WAIT_STATES+1), minimum 1.

**Load capture**
- On the clock edge ending the last STROBE cycle, mem_data_out is registered into resp_rdata.
- resp_rdata holds that value until the next load capture or reset.
- Stores leave resp_rdata unchanged.

**Response**
- resp_valid = 1 for exactly the RESP cycle.

## Timing
- Reset values: req_ready 0 while reset is high, and 1 on the first cycle after reset deasserts. resp_valid, resp_error, mem_read and mem_write are 0; mem_address, mem_data_in and resp_rdata are 0. State is IDLE.
- Cycles are counted after the accept edge E0:
  - cycle 1: SETUP
  - cycles 2..WAIT_STATES+2: STROBE
  - cycle WAIT_STATES+3: RESP
  - cycle WAIT_STATES+4: IDLE, and req_ready = 1 again
- Sustained throughput: one request per WAIT_STATES+4 cycles.
- The earliest back-to-back accept is at the edge ending the first IDLE cycle after RESP.
- Reset mid-operation: at the next edge the state returns to IDLE and all outputs take their reset values. No response is issued for the aborted request. A store interrupted in STROBE may already have updated the RAM; this is allowed.
- Address 0 and address DEPTH-1 are ordinary accesses, with no wrap logic.

## Configuration
- **MEM_CTRL_BOUNDS_CHECK_EN defined:** at accept, req_addr >= DEPTH goes IDLE -> RESP directly, skipping SETUP and STROBE.
  - No strobe is issued.
  - resp_error = 1 and resp_rdata = 0 in RESP.
  - Latency is 1 cycle.
  - In-range requests behave as above, with resp_error = 0.
- **Not defined:** resp_error is tied to 0, DEPTH is unused, and every address is forwarded to the RAM.

## Test plan
The bench uses a combinational 512-word RAM model with word 0x2B preloaded to 0x00000002, and WAIT_STATES = 1 unless a line says otherwise.

1. Store 0xDEADBEEF to 0x87, then load 0x87:
   - the store's mem_write is high for exactly 2 cycles, with mem_address = 0x87 starting 1 cycle before it;
   - the load's resp_valid is high in cycle 4 after accept, with resp_rdata = 0xDEADBEEF.
2. Load 0x2B:
   - resp_rdata = 0x00000002;
   - mem_write is never 1;
   - mem_data_in = 0 throughout.
3. WAIT_STATES = 0, load 0x2B: one mem_read cycle; resp_valid in cycle 3 after accept; req_ready is back in cycle 4.
4. After accepting a store of 0x11 to 0x10, change req_addr to 0x20 and req_wdata to 0x22 during SETUP. Only 0x10 is written; 0x20 is unchanged; a second req_valid held during busy is accepted only after RESP.
5. Assert reset in the first STROBE cycle of a store: the next cycle has all strobes 0, resp_valid never pulses, and req_ready = 1 one cycle after reset deasserts.
6. With MEM_CTRL_BOUNDS_CHECK_EN, load 0x200:
   - resp_valid and resp_error are high in cycle 1 after accept, with resp_rdata = 0;
   - no mem_read pulse occurs;
   - a load of 0x1FF completes normally with resp_error = 0.
